// File: rtl/oled_spi_rx_pkg.sv
// oled_pkg: framebuffer geometry, SSD1306 opcodes and FSM/addressing-mode encodings
package oled_pkg;
  localparam int COLS = 128;
  localparam int PAGES = 8;
  localparam int FB_DEPTH = 1024;
  localparam logic [7:0] CMD_MODE = 8'h20;
  localparam logic [7:0] CMD_COLADDR = 8'h21;
  localparam logic [7:0] CMD_PAGEADDR = 8'h22;
  localparam logic [7:0] CMD_DISP_OFF = 8'hAE;
  localparam logic [7:0] CMD_DISP_ON = 8'hAF;
  typedef logic [2:0] cmd_state_t;
  localparam cmd_state_t ST_IDLE = 3'd0;
  localparam cmd_state_t ST_ARG_MODE = 3'd1;
  localparam cmd_state_t ST_ARG_COL_S = 3'd2;
  localparam cmd_state_t ST_ARG_COL_E = 3'd3;
  localparam cmd_state_t ST_ARG_PG_S = 3'd4;
  localparam cmd_state_t ST_ARG_PG_E = 3'd5;
  localparam cmd_state_t ST_ARG_SKIP = 3'd6;
  typedef logic [1:0] addr_mode_t;
  localparam addr_mode_t MODE_HORIZ = 2'b00;
  localparam addr_mode_t MODE_PAGE = 2'b10;
  function automatic logic is_skip_cmd(input logic [7:0] b);
    return b inside {8'h81, 8'h8D, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB};
  endfunction
endpackage

// File: rtl/oled_spi_rx_if.sv
// oled_spi_rx_if: 4-wire SPI OLED link plus panel reset
interface oled_spi_rx_if;
  logic io_sclk;
  logic io_sdin;
  logic io_cs;
  logic io_dc;
  logic io_reset;
  modport master (output io_sclk, io_sdin, io_cs, io_dc, io_reset);
  modport slave (input io_sclk, io_sdin, io_cs, io_dc, io_reset);
endinterface

// File: rtl/oled_spi_rx_shift.sv
// oled_spi_shift: synchronizes the SPI pins and reassembles MSB-first bytes
module oled_spi_shift #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  oled_spi_rx_if.slave spi,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_is_dc,
  output logic       panel_rst
);
  logic [4:0] sync_q [SYNC_STAGES];
  logic [4:0] sync_d [SYNC_STAGES];
  logic [4:0] s;
  logic sclk_s, sdin_s, cs_s, dc_s, rise;
  logic sclk_prev_q, sclk_prev_d;
  logic [6:0] shift_q, shift_d;
  logic [2:0] cnt_q, cnt_d;
  logic byte_valid_q, byte_valid_d;
  logic [7:0] byte_data_q, byte_data_d;
  logic byte_is_dc_q, byte_is_dc_d;
  assign s = sync_q[SYNC_STAGES-1];
  assign sclk_s = s[0];
  assign sdin_s = s[1];
  assign cs_s = s[2];
  assign dc_s = s[3];
  assign panel_rst = ~s[4];
  assign rise = sclk_s & ~sclk_prev_q;
  always_comb begin
    sync_d[0] = {spi.io_reset, spi.io_dc, spi.io_cs, spi.io_sdin, spi.io_sclk};
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
  end
  always_comb begin
    sclk_prev_d = sclk_s;
    shift_d = shift_q;
    cnt_d = cnt_q;
    byte_valid_d = 1'b0;
    byte_data_d = byte_data_q;
    byte_is_dc_d = byte_is_dc_q;
    if (panel_rst) begin
      shift_d = '0;
      cnt_d = '0;
      byte_data_d = '0;
      byte_is_dc_d = 1'b0;
    end else if (cs_s) begin
      cnt_d = '0;
    end else if (rise) begin
      shift_d = {shift_q[5:0], sdin_s};
      cnt_d = cnt_q + 3'd1;
      byte_valid_d = cnt_q == 3'd7;
      byte_data_d = cnt_q == 3'd7 ? {shift_q, sdin_s} : byte_data_q;
      byte_is_dc_d = cnt_q == 3'd7 ? dc_s : byte_is_dc_q;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      sclk_prev_q <= 1'b0;
      shift_q <= '0;
      cnt_q <= '0;
      byte_valid_q <= 1'b0;
      byte_data_q <= '0;
      byte_is_dc_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      sclk_prev_q <= sclk_prev_d;
      shift_q <= shift_d;
      cnt_q <= cnt_d;
      byte_valid_q <= byte_valid_d;
      byte_data_q <= byte_data_d;
      byte_is_dc_q <= byte_is_dc_d;
    end
  end
  assign byte_valid = byte_valid_q;
  assign byte_data = byte_data_q;
  assign byte_is_dc = byte_is_dc_q;
endmodule

// File: rtl/oled_spi_rx.sv
// oled_spi_rx: SSD1306-style command decoder and 1024x8 framebuffer behind the SPI receiver
module oled_spi_rx #(
  parameter int COLS = 128,
  parameter int PAGES = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  oled_spi_rx_if.slave spi,
  input  logic [9:0] fb_rd_addr,
  output logic [7:0] fb_rd_data,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_is_dc,
  output logic       display_on,
  output logic       frame_done,
  output logic       cmd_err
);
  import oled_pkg::*;
  localparam int CW = $clog2(COLS);
  localparam int PW = $clog2(PAGES);
  logic panel_rst, wr_en;
  logic [7:0] b;
  cmd_state_t state_q, state_d;
  logic [CW-1:0] col_q, col_d, col_start_q, col_start_d, col_end_q, col_end_d;
  logic [PW-1:0] page_q, page_d, page_start_q, page_start_d, page_end_q, page_end_d;
  addr_mode_t mode_q, mode_d;
  logic display_on_q, display_on_d, frame_done_q, frame_done_d, cmd_err_q, cmd_err_d;
  logic [7:0] rd_q;
  logic [7:0] mem [FB_DEPTH];
  oled_spi_shift #(.SYNC_STAGES(SYNC_STAGES)) u_shift (
    .clk(clk), .rst(rst), .spi(spi),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_is_dc(byte_is_dc),
    .panel_rst(panel_rst)
  );
  assign b = byte_data;
  assign wr_en = byte_valid & byte_is_dc & ~panel_rst;
  always_comb begin
    state_d = state_q;
    col_d = col_q;
    page_d = page_q;
    col_start_d = col_start_q;
    col_end_d = col_end_q;
    page_start_d = page_start_q;
    page_end_d = page_end_q;
    mode_d = mode_q;
    display_on_d = display_on_q;
    frame_done_d = 1'b0;
    cmd_err_d = cmd_err_q;
    if (panel_rst) begin
      state_d = ST_IDLE;
      col_d = '0;
      page_d = '0;
      col_start_d = '0;
      col_end_d = CW'(COLS - 1);
      page_start_d = '0;
      page_end_d = PW'(PAGES - 1);
      mode_d = MODE_PAGE;
      display_on_d = 1'b0;
      cmd_err_d = 1'b0;
    end else if (byte_valid && byte_is_dc) begin
      // a data byte aborts any pending argument but is still stored
      state_d = ST_IDLE;
      cmd_err_d = cmd_err_q | (state_q != ST_IDLE);
      if (mode_q == MODE_PAGE || col_q != col_end_q) begin
        col_d = col_q + 1'b1;
      end else begin
        col_d = col_start_q;
        page_d = page_q == page_end_q ? page_start_q : page_q + 1'b1;
        frame_done_d = page_q == page_end_q;
      end
    end else if (byte_valid) begin
      case (state_q)
        ST_ARG_MODE: begin
          mode_d = b[1:0] == MODE_PAGE ? MODE_PAGE : MODE_HORIZ;
          state_d = ST_IDLE;
        end
        ST_ARG_COL_S: begin
          col_start_d = b[CW-1:0];
          state_d = ST_ARG_COL_E;
        end
        ST_ARG_COL_E: begin
          col_end_d = b[CW-1:0];
          col_d = col_start_q;
          state_d = ST_IDLE;
        end
        ST_ARG_PG_S: begin
          page_start_d = b[PW-1:0];
          state_d = ST_ARG_PG_E;
        end
        ST_ARG_PG_E: begin
          page_end_d = b[PW-1:0];
          page_d = page_start_q;
          state_d = ST_IDLE;
        end
        ST_ARG_SKIP: state_d = ST_IDLE;
        default: begin
          if (b == CMD_MODE) state_d = ST_ARG_MODE;
          else if (b == CMD_COLADDR) state_d = ST_ARG_COL_S;
          else if (b == CMD_PAGEADDR) state_d = ST_ARG_PG_S;
          else if (b[7:4] == 4'h0) col_d[3:0] = b[3:0];
          else if (b[7:3] == 5'b00010) col_d[CW-1:4] = b[CW-5:0];
          else if (b[7:3] == 5'b10110) page_d = b[PW-1:0];
          else if (b == CMD_DISP_ON || b == CMD_DISP_OFF) display_on_d = b[0];
          else if (is_skip_cmd(b)) state_d = ST_ARG_SKIP;
        end
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      col_q <= '0;
      page_q <= '0;
      col_start_q <= '0;
      col_end_q <= CW'(COLS - 1);
      page_start_q <= '0;
      page_end_q <= PW'(PAGES - 1);
      mode_q <= MODE_PAGE;
      display_on_q <= 1'b0;
      frame_done_q <= 1'b0;
      cmd_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q <= col_d;
      page_q <= page_d;
      col_start_q <= col_start_d;
      col_end_q <= col_end_d;
      page_start_q <= page_start_d;
      page_end_q <= page_end_d;
      mode_q <= mode_d;
      display_on_q <= display_on_d;
      frame_done_q <= frame_done_d;
      cmd_err_q <= cmd_err_d;
    end
  end
  // read-first: the read below sees the pre-write contents of the same address
  always_ff @(posedge clk) begin
    if (wr_en) mem[{page_q, col_q}] <= byte_data;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_q <= '0;
    else rd_q <= panel_rst ? 8'h00 : mem[fb_rd_addr];
  end
  assign fb_rd_data = rd_q;
  assign display_on = display_on_q;
  assign frame_done = frame_done_q;
  assign cmd_err = cmd_err_q;
endmodule

// File: tb/tb_oled_spi_rx.sv
// tb_oled_spi_rx: scoreboarded byte stream plus framebuffer/status checks
module tb_oled_spi_rx;
  typedef struct { logic [7:0] b; logic dc; } exp_t;
  typedef struct { logic [9:0] a; logic [7:0] e; } fbv_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [9:0] fb_rd_addr = '0;
  logic [7:0] fb_rd_data, byte_data;
  logic byte_valid, byte_is_dc, display_on, frame_done, cmd_err;
  int total = 0, bad = 0, nbytes = 0, frames = 0, frame_at = 0;
  exp_t q[$];
  fbv_t t3[4], t6[3];
  oled_spi_rx_if spi();
  oled_spi_rx dut (
    .clk(clk), .rst(rst), .spi(spi), .fb_rd_addr(fb_rd_addr), .fb_rd_data(fb_rd_data),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_is_dc(byte_is_dc),
    .display_on(display_on), .frame_done(frame_done), .cmd_err(cmd_err)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (byte_valid) begin
      exp_t e;
      nbytes++;
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_byte: got %02h dc=%0b, none expected", byte_data, byte_is_dc);
      end else begin
        e = q.pop_front();
        if ({byte_is_dc, byte_data} !== {e.dc, e.b}) begin
          bad++;
          $display("FAIL byte: got %02h dc=%0b, want %02h dc=%0b", byte_data, byte_is_dc, e.b, e.dc);
        end
      end
    end
    if (frame_done) begin
      frames++;
      frame_at = nbytes;
    end
  end
  initial begin
    #900us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask
  task automatic send_bits(input logic [7:0] b, input int n);
    spi.io_cs = 1'b0;
    for (int i = 0; i < n; i++) begin
      spi.io_sclk = 1'b0;
      spi.io_sdin = b[7-i];
      tick(2);
      spi.io_sclk = 1'b1;
      tick(2);
    end
    spi.io_sclk = 1'b0;
  endtask
  task automatic send(input logic [7:0] b, input logic dc);
    q.push_back('{b: b, dc: dc});
    spi.io_dc = dc;
    send_bits(b, 8);
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 40) begin
      tick(1);
      n++;
    end
    chk("drain", q.size(), 0);
    q.delete();
    tick(2);
  endtask
  task automatic fb_chk(input logic [9:0] a, input logic [7:0] e);
    fb_rd_addr = a;
    tick(1);
    chk($sformatf("fb[%0d]", a), fb_rd_data, e);
  endtask
  initial begin
    logic [7:0] cmds2[8], cmds3[6], cmds6[5];
    int bb, fb0;
    cmds2 = '{8'h20, 8'h00, 8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07};
    cmds3 = '{8'h21, 8'h7E, 8'h7F, 8'h22, 8'h06, 8'h07};
    cmds6 = '{8'h20, 8'h02, 8'hB3, 8'h0F, 8'h17};
    t3 = '{'{10'd894, 8'hD5}, '{10'd895, 8'hD2}, '{10'd1022, 8'hD3}, '{10'd1023, 8'hD4}};
    t6 = '{'{10'd511, 8'h11}, '{10'd384, 8'h22}, '{10'd385, 8'h33}};
    spi.io_sclk = 1'b0; spi.io_sdin = 1'b0; spi.io_cs = 1'b1; spi.io_dc = 1'b0; spi.io_reset = 1'b1;
    // 1: reset state, then rst mid-byte
    tick(2);
    chk("rst byte_valid", byte_valid, 0);
    chk("rst byte_data", byte_data, 0);
    chk("rst display_on", display_on, 0);
    chk("rst frame_done", frame_done, 0);
    chk("rst cmd_err", cmd_err, 0);
    chk("rst fb_rd_data", fb_rd_data, 0);
    rst = 1'b0;
    tick(4);
    send(8'h3C, 1'b0);
    drain();
    chk("byte_data 3C", byte_data, 8'h3C);
    send_bits(8'hFF, 5);
    rst = 1'b1;
    tick(2);
    chk("mid rst byte_data", byte_data, 0);
    rst = 1'b0;
    tick(4);
    send(8'hA5, 1'b0);
    drain();
    chk("byte_data A5", byte_data, 8'hA5);
    // 2: full horizontal frame
    foreach (cmds2[i]) send(cmds2[i], 1'b0);
    drain();
    bb = nbytes; fb0 = frames;
    for (int i = 0; i < 1024; i++) send(8'(i), 1'b1);
    drain();
    chk("t2 frames", frames - fb0, 1);
    chk("t2 frame_at", frame_at - bb, 1024);
    for (int i = 0; i < 1024; i++) fb_chk(10'(i), 8'(i));
    // 3: 2x2 window wrap
    foreach (cmds3[i]) send(cmds3[i], 1'b0);
    drain();
    bb = nbytes; fb0 = frames;
    for (int i = 1; i <= 5; i++) send(8'hD0 + 8'(i), 1'b1);
    drain();
    chk("t3 frames", frames - fb0, 1);
    chk("t3 frame_at", frame_at - bb, 4);
    for (int i = 0; i < 4; i++) fb_chk(t3[i].a, t3[i].e);
    // 4: data byte while an argument is pending
    send(8'h21, 1'b0);
    send(8'h55, 1'b1);
    drain();
    chk("t4 cmd_err", cmd_err, 1);
    fb_chk(10'd895, 8'h55);
    send(8'hAF, 1'b0);
    drain();
    chk("t4 idle display_on", display_on, 1);
    send(8'hAE, 1'b0);
    drain();
    chk("t4 display_off", display_on, 0);
    send(8'h66, 1'b1);
    drain();
    fb_chk(10'd1022, 8'h66);
    chk("t4 cmd_err sticky", cmd_err, 1);
    // 5: partial byte dropped by cs
    send_bits(8'hFF, 3);
    spi.io_cs = 1'b1;
    tick(6);
    send(8'hAF, 1'b0);
    drain();
    chk("t5 display_on", display_on, 1);
    chk("t5 byte_data", byte_data, 8'hAF);
    // 6: page mode wrap
    fb0 = frames;
    foreach (cmds6[i]) send(cmds6[i], 1'b0);
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    send(8'h33, 1'b1);
    drain();
    chk("t6 frames", frames - fb0, 0);
    for (int i = 0; i < 3; i++) fb_chk(t6[i].a, t6[i].e);
    // panel reset pin
    spi.io_reset = 1'b0;
    tick(4);
    chk("io_reset display_on", display_on, 0);
    chk("io_reset cmd_err", cmd_err, 0);
    chk("io_reset byte_data", byte_data, 0);
    spi.io_reset = 1'b1;
    tick(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
